seven_seg_scan_driver: RTL and testbench

Parametrised multiplexed driver for common-anode seven-segment displays, generalising the fixed 4-digit scanner to NUM_DIGITS digits.
- Generates its own refresh timebase; no separate anode clock module.
- Adds a decimal point, per-digit blanking, dead-time between digits against ghosting, and PWM brightness control.
- Double-buffers all display inputs at frame boundaries so the displayed frame never tears.
- Sits between display-formatting logic (digit encoders) and the board pins.

---
 rtl/seven_seg_scan_driver.sv | 117 +++++++++++
 tb/tb_seven_seg_scan_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner for NUM_DIGITS digits.
// Provides its own refresh timebase, per-slot dead-time, per-digit blanking,
// PWM brightness and frame-aligned double buffering of every display input.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 65536,
   parameter int DEAD_CYCLES = 256,
   parameter int BRIGHT_W    = 4,
   localparam int SCAN_W     = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int PRE_W      = $clog2(REFRESH_DIV)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              cathode,
   output logic                    dp,
   output logic [SCAN_W-1:0]       scan_idx,
   output logic                    frame_start
);

   logic [PRE_W-1:0]      r_pre_cnt;
   logic [SCAN_W-1:0]     r_scan_idx;

   logic [6:0]            r_dig_s [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] r_dp_s;
   logic [NUM_DIGITS-1:0] r_en_s;
   logic [BRIGHT_W-1:0]   r_bright_s;

   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_cathode;
   logic                  r_dp;
   logic                  r_frame_start;

   logic                  w_pre_last;
   logic                  w_scan_last;
   logic                  w_load;
   logic [BRIGHT_W-1:0]   w_phase;
   logic                  w_duty_on;
   logic                  w_active;
   logic [NUM_DIGITS-1:0] w_onehot;

   assign w_pre_last  = (r_pre_cnt == PRE_W'(REFRESH_DIV - 1));
   assign w_scan_last = (r_scan_idx == SCAN_W'(NUM_DIGITS - 1));
   // A frame begins when both counters sit at zero, including right after reset.
   assign w_load      = (r_pre_cnt == '0) && (r_scan_idx == '0);
   // PWM phase comes from the low prescaler bits, so each slot holds whole PWM periods.
   assign w_phase     = r_pre_cnt[BRIGHT_W-1:0];
   assign w_duty_on   = (&r_bright_s) || (w_phase < r_bright_s);
   assign w_active    = (r_pre_cnt >= PRE_W'(DEAD_CYCLES)) && r_en_s[r_scan_idx] && w_duty_on;
   assign w_onehot    = NUM_DIGITS'(1) << r_scan_idx;

   // Prescaler and digit slot counter; slot wraps explicitly for non-power-of-2 digit counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt  <= '0;
         r_scan_idx <= '0;
      end else begin
         if (w_pre_last) begin
            r_pre_cnt  <= '0;
            r_scan_idx <= w_scan_last ? '0 : r_scan_idx + SCAN_W'(1);
         end else begin
            r_pre_cnt  <= r_pre_cnt + PRE_W'(1);
         end
      end
   end

   // Shadow copies of the display inputs, refreshed only at the frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            r_dig_s[k] <= 7'h7F;
         end
         r_dp_s     <= '1;
         r_en_s     <= '0;
         r_bright_s <= '0;
      end else if (w_load) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            r_dig_s[k] <= digits[7*k +: 7];
         end
         r_dp_s     <= dp_in;
         r_en_s     <= digit_en;
         r_bright_s <= brightness;
      end
   end

   // Registered pin drive; segments are forced dark whenever no anode is on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an          <= '1;
         r_cathode     <= 7'h7F;
         r_dp          <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_load;
         if (w_active) begin
            r_an      <= ~w_onehot;
            r_cathode <= r_dig_s[r_scan_idx];
            r_dp      <= r_dp_s[r_scan_idx];
         end else begin
            r_an      <= '1;
            r_cathode <= 7'h7F;
            r_dp      <= 1'b1;
         end
      end
   end

   assign an          = r_an;
   assign cathode     = r_cathode;
   assign dp          = r_dp;
   assign scan_idx    = r_scan_idx;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver with a small 4-digit geometry
// (16 cycles per slot, 2 dead cycles, 2-bit brightness).
module tb_seven_seg_scan_driver;

   localparam int ND   = 4;
   localparam int RD   = 16;
   localparam int DC   = 2;
   localparam int BW   = 2;
   localparam int FRM  = ND * RD;

   logic            clk;
   logic            rst_n;
   logic [7*ND-1:0] digits;
   logic [ND-1:0]   dp_in;
   logic [ND-1:0]   digit_en;
   logic [BW-1:0]   brightness;
   logic [ND-1:0]   an;
   logic [6:0]      cathode;
   logic            dp;
   logic [1:0]      scan_idx;
   logic            frame_start;

   int total = 0;
   int bad   = 0;

   seven_seg_scan_driver #(
      .NUM_DIGITS (ND),
      .REFRESH_DIV(RD),
      .DEAD_CYCLES(DC),
      .BRIGHT_W   (BW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits     (digits),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .brightness (brightness),
      .an         (an),
      .cathode    (cathode),
      .dp         (dp),
      .scan_idx   (scan_idx),
      .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: time since release measured in edges, display state by division.
   int         m_edges;
   logic [6:0] m_dig [ND];
   logic [3:0] m_dp;
   logic [3:0] m_en;
   logic [1:0] m_br;
   logic [3:0] e_an;
   logic [6:0] e_cat;
   logic       e_dp;
   logic       e_fs;
   logic [1:0] e_scan;

   function automatic bit lit(input int ed);
      int pre;
      int slot;
      pre  = ed % RD;
      slot = (ed / RD) % ND;
      return (pre >= DC) && m_en[slot] && ((m_br == 2'b11) || ((pre % 4) < int'(m_br)));
   endfunction

   function automatic logic [3:0] exp_an(input int ed);
      int slot;
      slot = (ed / RD) % ND;
      if (lit(ed)) return ~(4'b0001 << slot);
      return 4'hF;
   endfunction

   function automatic logic [6:0] exp_cat(input int ed);
      int slot;
      slot = (ed / RD) % ND;
      if (lit(ed)) return m_dig[slot];
      return 7'h7F;
   endfunction

   function automatic logic exp_dp(input int ed);
      int slot;
      slot = (ed / RD) % ND;
      if (lit(ed)) return m_dp[slot];
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edges <= 0;
         for (int k = 0; k < ND; k++) m_dig[k] <= 7'h7F;
         m_dp   <= 4'hF;
         m_en   <= 4'h0;
         m_br   <= 2'b00;
         e_an   <= 4'hF;
         e_cat  <= 7'h7F;
         e_dp   <= 1'b1;
         e_fs   <= 1'b0;
         e_scan <= 2'd0;
      end else begin
         m_edges <= m_edges + 1;
         e_an    <= exp_an(m_edges);
         e_cat   <= exp_cat(m_edges);
         e_dp    <= exp_dp(m_edges);
         e_fs    <= (m_edges % FRM == 0);
         e_scan  <= 2'(((m_edges + 1) / RD) % ND);
         if (m_edges % FRM == 0) begin
            for (int k = 0; k < ND; k++) m_dig[k] <= digits[7*k +: 7];
            m_dp <= dp_in;
            m_en <= digit_en;
            m_br <= brightness;
         end
      end
   end

   // Every-cycle comparison against the model plus the single-anode invariant.
   always @(negedge clk) begin
      chk_eq("an", 32'(an), 32'(e_an));
      chk_eq("cathode", 32'(cathode), 32'(e_cat));
      chk_eq("dp", 32'(dp), 32'(e_dp));
      chk_eq("scan_idx", 32'(scan_idx), 32'(e_scan));
      chk_eq("frame_start", 32'(frame_start), 32'(e_fs));
      chk_eq("an_onehot", 32'($countones(~an) <= 1), 32'd1);
   end

   task automatic wait_fs();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3 * FRM && !seen; i++) begin
         @(negedge clk);
         if (frame_start) seen = 1'b1;
      end
      chk_eq("frame_start_timeout", 32'(seen), 32'd1);
   endtask

   // Count lit cycles over one frame, starting at the frame_start cycle.
   task automatic count_lit(output int n);
      n = 0;
      wait_fs();
      for (int i = 0; i < FRM; i++) begin
         if (i != 0) @(negedge clk);
         if (an != 4'hF) n++;
      end
   endtask

   int lit_cnt;

   initial begin
      rst_n      = 1'b0;
      digits     = {7'h40, 7'h79, 7'h24, 7'h30};
      dp_in      = 4'hF;
      digit_en   = 4'hF;
      brightness = 2'b11;
      repeat (3) @(negedge clk);
      chk_eq("reset_an", 32'(an), 32'hF);
      chk_eq("reset_cathode", 32'(cathode), 32'h7F);
      chk_eq("reset_scan", 32'(scan_idx), 32'd0);

      // First frame after release, then a mid-slot-2 change of digit 0.
      rst_n = 1'b1;
      for (int k = 1; k <= 133; k++) begin
         @(negedge clk);
         if (k == 1 || k == 65 || k == 129) chk_eq("fs_pulse", 32'(frame_start), 32'd1);
         if (k == 2 || k == 64) chk_eq("fs_quiet", 32'(frame_start), 32'd0);
         if (k <= 2) chk_eq("dead_an", 32'(an), 32'hF);
         if (k >= 3 && k <= 16) begin
            chk_eq("slot0_an", 32'(an), 32'hE);
            chk_eq("slot0_cat", 32'(cathode), 32'h30);
         end
         if (k == 17 || k == 18) chk_eq("slot1_dead", 32'(an), 32'hF);
         if (k == 19) begin
            chk_eq("slot1_an", 32'(an), 32'hD);
            chk_eq("slot1_cat", 32'(cathode), 32'h24);
         end
         if (k == 104) digits[6:0] = 7'h19;
         if (k == 133) begin
            chk_eq("tear_an", 32'(an), 32'hE);
            chk_eq("tear_cat", 32'(cathode), 32'h19);
         end
      end

      // Blanking of alternate digits.
      digit_en = 4'b1010;
      count_lit(lit_cnt);
      chk_eq("blank_lit_cycles", 32'(lit_cnt), 32'd28);

      // Quarter and zero brightness.
      digit_en   = 4'hF;
      brightness = 2'b01;
      count_lit(lit_cnt);
      chk_eq("bright1_lit_cycles", 32'(lit_cnt), 32'd12);
      brightness = 2'b00;
      count_lit(lit_cnt);
      chk_eq("bright0_lit_cycles", 32'(lit_cnt), 32'd0);

      // Decimal point on digit 3 at full brightness.
      brightness = 2'b11;
      dp_in      = 4'b0111;
      count_lit(lit_cnt);
      chk_eq("full_lit_cycles", 32'(lit_cnt), 32'd56);

      // Reset asserted in the middle of slot 2.
      wait_fs();
      repeat (36) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("midrst_an", 32'(an), 32'hF);
      chk_eq("midrst_cat", 32'(cathode), 32'h7F);
      chk_eq("midrst_scan", 32'(scan_idx), 32'd0);
      chk_eq("midrst_fs", 32'(frame_start), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) chk_eq("restart_fs", 32'(frame_start), 32'd1);
         if (k == 2) chk_eq("restart_dead", 32'(an), 32'hF);
         if (k == 3) chk_eq("restart_an", 32'(an), 32'hE);
      end

      // Randomized input changes and occasional asynchronous resets.
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(1, 60)) @(negedge clk);
         digits     = 28'($urandom);
         dp_in      = 4'($urandom);
         digit_en   = 4'($urandom);
         brightness = 2'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      repeat (2 * FRM) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
